// File: rtl/mips_alu.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu
// Purpose  : 32-bit MIPS-style execute-stage ALU with registered result/zero.
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [4:0]       shamt,
    input  logic [3:0]       select,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag
);

    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_OR   = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd6;
    localparam logic [3:0] c_OP_SLT  = 4'd7;
    localparam logic [3:0] c_OP_SLTU = 4'd8;
    localparam logic [3:0] c_OP_XOR  = 4'd9;
    localparam logic [3:0] c_OP_NOR  = 4'd10;
    localparam logic [3:0] c_OP_SLL  = 4'd11;
    localparam logic [3:0] c_OP_SRL  = 4'd12;

    logic [WIDTH-1:0] w_result;
    logic             w_lt_signed;
    logic             w_lt_unsigned;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;

    // Signed compare uses the native signed operator, so it stays correct
    // where a subtract-and-check-sign scheme would overflow.
    assign w_lt_signed   = $signed(reg1) < $signed(reg2);
    assign w_lt_unsigned = reg1 < reg2;

    always_comb begin
        w_result = '0;
        case (select)
            c_OP_AND:  w_result = reg1 & reg2;
            c_OP_OR:   w_result = reg1 | reg2;
            c_OP_ADD:  w_result = reg1 + reg2;
            c_OP_SUB:  w_result = reg1 - reg2;
            c_OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
            c_OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
            c_OP_XOR:  w_result = reg1 ^ reg2;
            c_OP_NOR:  w_result = ~(reg1 | reg2);
            c_OP_SLL:  w_result = reg2 << shamt;
            c_OP_SRL:  w_result = reg2 >> shamt;
            default:   w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_zero <= 1'b1;
        end else begin
            r_out  <= w_result;
            r_zero <= (w_result == '0);
        end
    end

    assign out       = r_out;
    assign zero_flag = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_alu
// Purpose  : Table-driven directed check of mips_alu plus reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  shamt;
    logic [3:0]  select;
    logic [31:0] out;
    logic        zero_flag;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_out;
        logic        exp_z;
    } vec_t;

    vec_t tbl[$];

    mips_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg1      (reg1),
        .reg2      (reg2),
        .shamt     (shamt),
        .select    (select),
        .out       (out),
        .zero_flag (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] e);
        vec_t v;
        v.sel = s; v.a = a; v.b = b; v.sh = sh; v.exp_out = e; v.exp_z = (e == 32'h0);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] e, input logic ez);
        n_vec++;
        if (out !== e || zero_flag !== ez) begin
            n_err++;
            $display("FAIL %s: got out=%08h zero=%b, expected out=%08h zero=%b",
                     name, out, zero_flag, e, ez);
        end
    endtask

    task automatic drive(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        select = s; reg1 = a; reg2 = b; shamt = sh;
    endtask

    logic [31:0] prev_out;
    logic        prev_z;

    initial begin
        n_vec = 0;
        n_err = 0;

        // Arithmetic / logic / compare / shift on -2, -1, shamt=2
        add(4'd2,  32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFD);
        add(4'd6,  32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF);
        add(4'd0,  32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE);
        add(4'd1,  32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF);
        add(4'd9,  32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'h00000001);
        add(4'd10, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'h00000000);
        add(4'd7,  32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'h00000001);
        add(4'd8,  32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'h00000001);
        add(4'd11, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFC);
        add(4'd12, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd2,  32'h3FFFFFFF);
        add(4'd11, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF);
        add(4'd12, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF);
        add(4'd11, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd31, 32'h80000000);
        add(4'd12, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd31, 32'h00000001);
        // Signed vs unsigned compare corners
        add(4'd7,  32'h80000000, 32'h00000001, 5'd3,  32'h00000001);
        add(4'd8,  32'h80000000, 32'h00000001, 5'd3,  32'h00000000);
        add(4'd7,  32'h80000000, 32'h7FFFFFFF, 5'd0,  32'h00000001);
        add(4'd7,  32'h00000005, 32'h00000003, 5'd0,  32'h00000000);
        add(4'd8,  32'h00000003, 32'h00000005, 5'd0,  32'h00000001);
        add(4'd8,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000);
        add(4'd7,  32'h00000004, 32'h00000004, 5'd0,  32'h00000000);
        // Bit patterns, wraparound, logical right shift, reg1 ignored by shifts
        add(4'd0,  32'hA5A5A5A5, 32'h0F0F0F0F, 5'd7,  32'h05050505);
        add(4'd1,  32'hA5A5A5A5, 32'h0F0F0F0F, 5'd7,  32'hAFAFAFAF);
        add(4'd9,  32'hA5A5A5A5, 32'h0F0F0F0F, 5'd7,  32'hAAAAAAAA);
        add(4'd10, 32'hA5A5A5A5, 32'h0F0F0F0F, 5'd7,  32'h50505050);
        add(4'd2,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000);
        add(4'd2,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000);
        add(4'd6,  32'h00001234, 32'h00001234, 5'd0,  32'h00000000);
        add(4'd6,  32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF);
        add(4'd12, 32'hDEADBEEF, 32'h80000000, 5'd4,  32'h08000000);
        add(4'd11, 32'hDEADBEEF, 32'h00000001, 5'd4,  32'h00000010);
        // Undefined codes
        add(4'd13, 32'h12345678, 32'h9ABCDEF0, 5'd5,  32'h00000000);
        add(4'd3,  32'h12345678, 32'h9ABCDEF0, 5'd5,  32'h00000000);
        add(4'd4,  32'h12345678, 32'h9ABCDEF0, 5'd5,  32'h00000000);
        add(4'd5,  32'h12345678, 32'h9ABCDEF0, 5'd5,  32'h00000000);
        add(4'd14, 32'h12345678, 32'h9ABCDEF0, 5'd5,  32'h00000000);
        add(4'd15, 32'h12345678, 32'h9ABCDEF0, 5'd5,  32'h00000000);

        // Reset held for two edges with live inputs
        rst_n = 1'b0;
        drive(4'd2, 32'h00000005, 32'h00000007, 5'd1);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", 32'h0, 1'b1);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("reset_release_add", 32'h0000000C, 1'b0);
        prev_out = 32'h0000000C;
        prev_z   = 1'b0;

        // Select changes every cycle; output must hold until the next edge
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].sh);
            #1 check($sformatf("hold_before_v%0d", i), prev_out, prev_z);
            @(posedge clk);
            #1 check($sformatf("vec%0d_sel%0d", i, tbl[i].sel), tbl[i].exp_out, tbl[i].exp_z);
            prev_out = tbl[i].exp_out;
            prev_z   = tbl[i].exp_z;
        end

        // Reset asserted mid-stream clears a nonzero result on that edge
        @(negedge clk) drive(4'd1, 32'h0000F000, 32'h0000000F, 5'd0);
        @(posedge clk);
        #1 check("pre_reset_or", 32'h0000F00F, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'd2, 32'h00000001, 32'h00000001, 5'd0);
        @(posedge clk);
        #1 check("mid_reset", 32'h0, 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_reset_add", 32'h00000002, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit MIPS-style integer ALU for the processor datapath's execute stage.
- Selects one of ten operations (logic, add/sub, signed/unsigned compare, shifts) on two register operands and a 5-bit shift amount.
- Result and zero flag are registered: one clock of latency, synchronous active-low reset.

Parameters:
- WIDTH, 32, operand/result width. Shift amount stays 5 bits; the design and bench target WIDTH=32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- reg1  input  WIDTH  operand A (rs)
- reg2  input  WIDTH  operand B (rt); also the shift source
- shamt  input  5  shift amount for sll/srl
- select  input  4  operation code
- out  output  WIDTH  registered result
- zero_flag  output  1  registered; 1 when out is all zeros

Behaviour:
- Both outputs are registers, updated only on the rising edge of clk.
- Reset: when rst_n=0 at a rising edge, out <= 0 and zero_flag <= 1. Reset has priority over computation.
- When rst_n=1, each edge captures result(select, reg1, reg2, shamt) from the current inputs. Latency is exactly 1 cycle; there is no handshake and no stall.
- Operation codes (decimal):
  - 0 AND: reg1 & reg2
  - 1 OR: reg1 | reg2
  - 2 ADD: reg1 + reg2, modulo 2^WIDTH; overflow ignored, no trap
  - 6 SUB: reg1 - reg2, modulo 2^WIDTH; overflow ignored
  - 7 SLT: 1 if reg1 < reg2 as two's-complement signed, else 0; zero-extended to WIDTH. Must be correct across overflow (e.g. 0x80000000 < 0x7FFFFFFF gives 1).
  - 8 SLTU: 1 if reg1 < reg2 unsigned, else 0; zero-extended
  - 9 XOR: reg1 ^ reg2
  - 10 NOR: ~(reg1 | reg2)
  - 11 SLL: reg2 << shamt, zero fill. reg1 is ignored.
  - 12 SRL: reg2 >> shamt, logical, zero fill. reg1 is ignored.
- Undefined codes (3, 4, 5, 13, 14, 15): result is 0, so zero_flag=1.
- shamt=0 passes reg2 unchanged for SLL/SRL. shamt is ignored by all other codes.
- zero_flag is computed from the same next-state result and registered alongside out, so the two are always mutually consistent.
- X-free: every output bit has a defined value for every input combination.
- The computation path (adder/subtractor, comparators, barrel shifter, select mux) is purely combinational ahead of the output registers.
- Inputs may change every cycle; each cycle's result is independent (no internal state besides the output registers).

Test Plan:
- Reset: hold rst_n=0 for 2 edges with arbitrary inputs -> out=0x00000000, zero_flag=1. Release -> the next edge shows the computed result.
- Arithmetic with reg1=0xFFFFFFFE (-2), reg2=0xFFFFFFFF (-1), shamt=2, one edge per code:
  - select=2 -> out=0xFFFFFFFD, zero_flag=0
  - select=6 -> out=0xFFFFFFFF, zero_flag=0
- Logic, same operands:
  - select=0 -> 0xFFFFFFFE
  - select=1 -> 0xFFFFFFFF
  - select=9 -> 0x00000001
  - select=10 -> 0x00000000 with zero_flag=1
- Compare, same operands:
  - select=7 -> 0x00000001
  - select=8 -> 0x00000001
  - Also reg1=0x80000000, reg2=0x00000001: SLT -> 1, SLTU -> 0
- Shifts, same operands:
  - select=11 -> 0xFFFFFFFC
  - select=12 -> 0x3FFFFFFF
  - shamt=0 -> 0xFFFFFFFF for both codes
  - shamt=31 -> 0x80000000 (SLL) and 0x00000001 (SRL)
- Latency and edge cases:
  - Change select every cycle; confirm each result appears exactly one edge later.
  - ADD 0x7FFFFFFF + 1 -> 0x80000000 (no trap).
  - SUB of equal operands -> 0, zero_flag=1.
  - Undefined select=13 -> out=0, zero_flag=1.
  - Assert rst_n=0 mid-sequence -> outputs clear on that edge.
